// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch path (read-only) and the
// stack path (read/write). Round-robin choice between the two requesters,
// one access in flight, fixed-latency read data returned on a registered
// valid strobe to whichever port owns the access. All outputs are registers.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2    // legal 1..15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    // fetch port
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    // stack port
    input  logic          st_req_i,
    input  logic          st_we_i,
    input  logic [AW-1:0] st_addr_i,
    input  logic [DW-1:0] st_wdata_i,
    output logic          st_gnt_o,
    output logic          st_rvalid_o,
    output logic [DW-1:0] st_rdata_o,
    // memory side
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            owner_st_q, owner_st_d;   // 1 = stack owns the access
    logic            last_st_q, last_st_d;     // 1 = stack was granted last
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            if_gnt_q, if_gnt_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic            st_gnt_q, st_gnt_d;
    logic            st_rvalid_q, st_rvalid_d;
    logic [DW-1:0]   st_rdata_q, st_rdata_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            busy_q, busy_d;

    logic            pick_st;
    logic [AW-1:0]   sel_addr;

    // Next-state and next-output logic; outputs are computed one cycle early
    // so that every port is driven straight from a flop.
    always_comb begin
        state_d     = state_q;
        owner_st_d  = owner_st_q;
        last_st_d   = last_st_q;
        cnt_d       = cnt_q;
        if_gnt_d    = 1'b0;
        st_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        st_rvalid_d = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        st_rdata_d  = st_rdata_q;

        // Stack wins when it is the only requester, or when both ask and
        // fetch was the last one served.
        pick_st  = st_req_i && (!if_req_i || !last_st_q);
        sel_addr = pick_st ? st_addr_i : if_addr_i;

        unique case (state_q)
            S_IDLE: begin
                if (if_req_i || st_req_i) begin
                    owner_st_d  = pick_st;
                    last_st_d   = pick_st;
                    if_gnt_d    = !pick_st;
                    st_gnt_d    = pick_st;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_st && st_we_i;
                    // Low address bits are simply dropped; no misalignment flag.
                    mem_addr_d  = sel_addr & ~AW'(3);
                    mem_wdata_d = st_wdata_i;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_we_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = CW'(MEM_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // This edge ends cycle ACCESS+MEM_LAT, where the word is valid.
                    if (owner_st_q) begin
                        st_rvalid_d = 1'b1;
                        st_rdata_d  = mem_rdata_i;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata_i;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops any in-flight read silently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            owner_st_q  <= 1'b0;
            last_st_q   <= 1'b1;
            cnt_q       <= '0;
            if_gnt_q    <= 1'b0;
            st_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            st_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            st_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_st_q  <= owner_st_d;
            last_st_q   <= last_st_d;
            cnt_q       <= cnt_d;
            if_gnt_q    <= if_gnt_d;
            st_gnt_q    <= st_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            st_rvalid_q <= st_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            st_rdata_q  <= st_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt_o    = if_gnt_q;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign st_gnt_o    = st_gnt_q;
    assign st_rvalid_o = st_rvalid_q;
    assign st_rdata_o  = st_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT = 1, 2, 15) run the
// same directed script. Each instance has a memory responder, a timeline model
// that schedules expected outputs per cycle number, and a per-cycle checker.
module tb_mem_port_arbiter;

    localparam int NC = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endfunction

    function automatic bit [31:0] init_word(bit [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_lat
        localparam int LAT     = (gi == 0) ? 1 : (gi == 1) ? 2 : 15;
        localparam int RV_DIST = (gi == 0) ? 2 : (gi == 1) ? 3 : 16;

        logic        rst_n = 1'b1;
        logic        if_req = 1'b0;
        logic [31:0] if_addr = '0;
        logic        st_req = 1'b0;
        logic        st_we = 1'b0;
        logic [31:0] st_addr = '0;
        logic [31:0] st_wdata = '0;
        logic [31:0] mem_rdata = '0;
        logic        if_gnt, if_rvalid, st_gnt, st_rvalid;
        logic        mem_en, mem_we, busy;
        logic [31:0] if_rdata, st_rdata, mem_addr, mem_wdata;
        bit          fin = 1'b0;

        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
            .clk_i(clk), .rst_ni(rst_n),
            .if_req_i(if_req), .if_addr_i(if_addr),
            .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
            .st_req_i(st_req), .st_we_i(st_we), .st_addr_i(st_addr),
            .st_wdata_i(st_wdata),
            .st_gnt_o(st_gnt), .st_rvalid_o(st_rvalid), .st_rdata_o(st_rdata),
            .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
            .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
        );

        int          cyc = 0;
        bit          issued [NC];
        bit [31:0]   iaddr  [NC];
        bit [31:0]   rmem   [bit [31:0]];
        bit [31:0]   mmem   [bit [31:0]];
        bit          e_ifg [NC], e_stg [NC], e_en [NC], e_we [NC];
        bit          e_ifv [NC], e_stv [NC], e_busy [NC];
        bit [31:0]   e_addr [NC], e_wd [NC], e_ifd [NC], e_std [NC];
        int          free_at = 0;
        bit          last_st = 1'b1;

        // Memory responder + timeline model, both keyed on the cycle number.
        always @(posedge clk) begin : resp_model
            int c, g, r;
            bit ps;
            bit [31:0] a, d, a2;
            c = cyc;
            if (mem_en === 1'b1 && c < NC) begin
                issued[c] = 1'b1;
                iaddr[c]  = mem_addr;
                if (mem_we === 1'b1) rmem[mem_addr] = mem_wdata;
            end
            if (rst_n && c >= free_at && (if_req || st_req) && c + LAT + 3 < NC) begin
                ps      = st_req && (!if_req || !last_st);
                last_st = ps;
                a       = (ps ? st_addr : if_addr) & 32'hFFFF_FFFC;
                g       = c + 1;
                e_ifg[g] = !ps;  e_stg[g] = ps;  e_en[g] = 1'b1;
                e_we[g]  = ps && st_we;  e_addr[g] = a;  e_wd[g] = st_wdata;
                e_busy[g] = 1'b1;
                if (ps && st_we) begin
                    mmem[a] = st_wdata;
                    free_at = c + 2;
                end else begin
                    r = c + 2 + LAT;
                    for (int j = g; j <= r; j++) e_busy[j] = 1'b1;
                    d = mmem.exists(a) ? mmem[a] : init_word(a);
                    if (ps) begin
                        e_stv[r] = 1'b1;
                        for (int j = r; j < NC; j++) e_std[j] = d;
                    end else begin
                        e_ifv[r] = 1'b1;
                        for (int j = r; j < NC; j++) e_ifd[j] = d;
                    end
                    free_at = r + 1;
                end
            end
            cyc = c + 1;
            if (cyc >= LAT && cyc - LAT < NC && issued[cyc - LAT]) begin
                a2 = iaddr[cyc - LAT];
                mem_rdata <= rmem.exists(a2) ? rmem[a2] : init_word(a2);
            end else begin
                mem_rdata <= 32'hBAD0_0000 | 32'(cyc);
            end
        end

        // Reset wipes every expectation from the current cycle onward.
        always @(negedge rst_n) begin
            for (int j = cyc; j < NC; j++) begin
                e_ifg[j] = 0; e_stg[j] = 0; e_en[j] = 0; e_we[j] = 0;
                e_ifv[j] = 0; e_stv[j] = 0; e_busy[j] = 0;
                e_addr[j] = 0; e_wd[j] = 0; e_ifd[j] = 0; e_std[j] = 0;
            end
            free_at = 0;
            last_st = 1'b1;
        end

        // Per-cycle compare against the model, mid-cycle.
        always @(negedge clk) begin
            int k;
            k = cyc;
            if (k < NC) begin
                chk($sformatf("L%0d c%0d ctrl", LAT, k),
                    {if_gnt, st_gnt, mem_en, mem_we, if_rvalid, st_rvalid, busy},
                    {e_ifg[k], e_stg[k], e_en[k], e_we[k], e_ifv[k], e_stv[k], e_busy[k]});
                chk($sformatf("L%0d c%0d if_rdata", LAT, k), if_rdata, e_ifd[k]);
                chk($sformatf("L%0d c%0d st_rdata", LAT, k), st_rdata, e_std[k]);
                if (e_en[k]) begin
                    chk($sformatf("L%0d c%0d mem_addr", LAT, k), mem_addr, e_addr[k]);
                    chk($sformatf("L%0d c%0d mem_wdata", LAT, k), mem_wdata, e_wd[k]);
                end
            end
        end

        bit [31:0] cap_addr, cap_wd;
        bit        cap_we, cap_busy1;

        task automatic step();
            @(negedge clk);
            #1;
        endtask

        task automatic wait_idle();
            for (int i = 0; i < 40 && busy; i++) step();
        endtask

        task automatic xact(input bit stk, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, output int gc, output int rc,
                            output logic [31:0] rd);
            gc = -1; rc = -1; rd = '0;
            if (stk) begin
                st_req = 1'b1; st_we = we; st_addr = a; st_wdata = wd;
            end else begin
                if_req = 1'b1; if_addr = a;
            end
            for (int i = 0; i < 40 && gc < 0; i++) begin
                step();
                if (stk ? st_gnt : if_gnt) begin
                    gc = cyc; cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
                end
            end
            if_req = 1'b0; st_req = 1'b0;
            chk($sformatf("L%0d gnt_seen a=%h", LAT, a), gc >= 0, 1);
            if (gc >= 0 && stk && we) begin
                step();
                cap_busy1 = busy;
            end else if (gc >= 0) begin
                for (int i = 0; i < 40 && rc < 0; i++) begin
                    step();
                    if (stk ? st_rvalid : if_rvalid) begin
                        rc = cyc; rd = stk ? st_rdata : if_rdata;
                    end
                end
                chk($sformatf("L%0d rvalid_seen a=%h", LAT, a), rc >= 0, 1);
            end
            wait_idle();
            $display("L%0d %s %s addr=%h gnt@%0d rv@%0d data=%h", LAT,
                     stk ? "stack" : "fetch", (stk && we) ? "wr" : "rd", a, gc, rc,
                     (stk && we) ? wd : rd);
        endtask

        initial begin : drive
            int gc, rc, ng, nrv;
            logic [31:0] rd;
            bit [3:0] order;
            bit first_st;
            #1 rst_n = 1'b0;
            repeat (3) step();
            chk($sformatf("L%0d reset_ctrl", LAT),
                {if_gnt, if_rvalid, st_gnt, st_rvalid, mem_en, mem_we, busy}, 0);
            chk($sformatf("L%0d reset_data", LAT), {if_rdata, st_rdata}, 0);
            chk($sformatf("L%0d reset_mem", LAT), {mem_addr, mem_wdata}, 0);
            rst_n = 1'b1;
            repeat (3) step();
            chk($sformatf("L%0d idle_no_en", LAT), {mem_en, busy}, 0);

            xact(0, 0, 32'h40, 32'h0, gc, rc, rd);
            chk($sformatf("L%0d fetch40_data", LAT), rd, 32'hDEADBEEF);
            chk($sformatf("L%0d fetch40_addr", LAT), cap_addr, 32'h40);
            chk($sformatf("L%0d gnt_to_rvalid", LAT), rc - gc, RV_DIST);

            xact(0, 0, 32'h43, 32'h0, gc, rc, rd);
            chk($sformatf("L%0d align43", LAT), cap_addr, 32'h40);

            xact(1, 1, 32'h1FC, 32'h12345678, gc, rc, rd);
            chk($sformatf("L%0d wr_we", LAT), cap_we, 1);
            chk($sformatf("L%0d wr_addr", LAT), cap_addr, 32'h1FC);
            chk($sformatf("L%0d wr_wdata", LAT), cap_wd, 32'h12345678);
            chk($sformatf("L%0d wr_busy_after", LAT), cap_busy1, 0);

            xact(1, 0, 32'h1FE, 32'h0, gc, rc, rd);
            chk($sformatf("L%0d st_readback", LAT), rd, 32'h12345678);

            // Contention: both held high, last grant was stack.
            if_req = 1'b1; if_addr = 32'h80; st_req = 1'b1; st_we = 1'b0; st_addr = 32'h100;
            order = '0; ng = 0;
            for (int i = 0; i < 200 && ng < 4; i++) begin
                step();
                if (if_gnt || st_gnt) begin
                    order[ng] = st_gnt; ng++;
                end
            end
            if_req = 1'b0; st_req = 1'b0;
            chk($sformatf("L%0d contention_count", LAT), ng, 4);
            chk($sformatf("L%0d contention_order", LAT), order, 4'b1010);
            wait_idle();
            $display("L%0d contention grants=%0d order(F=0,S=1)=%b", LAT, ng, order);

            // Withdrawal: stack request shows up only while busy, then leaves.
            if_req = 1'b1; if_addr = 32'h200; gc = -1;
            for (int i = 0; i < 40 && gc < 0; i++) begin
                step();
                if (if_gnt) gc = cyc;
            end
            if_req = 1'b0;
            step();
            st_req = 1'b1; st_we = 1'b1; st_addr = 32'h300; st_wdata = 32'hCAFEF00D;
            step();
            st_req = 1'b0;
            ng = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (st_gnt) ng++;
            end
            chk($sformatf("L%0d withdrawn_no_gnt", LAT), ng, 0);
            $display("L%0d fetch rd addr=00000200 gnt@%0d with withdrawn stack req", LAT, gc);

            // Reset during WAIT: read vanishes, fetch goes first afterwards.
            if_req = 1'b1; if_addr = 32'h44; gc = -1;
            for (int i = 0; i < 40 && gc < 0; i++) begin
                step();
                if (if_gnt) gc = cyc;
            end
            if_req = 1'b0;
            chk($sformatf("L%0d midrd_gnt_seen", LAT), gc >= 0, 1);
            step();
            rst_n = 1'b0;
            nrv = 0;
            repeat (LAT + 5) begin
                step();
                nrv += int'(if_rvalid | st_rvalid);
            end
            chk($sformatf("L%0d midrd_no_rvalid", LAT), nrv, 0);
            chk($sformatf("L%0d midrd_busy", LAT), busy, 0);
            rst_n = 1'b1;
            step();
            if_req = 1'b1; if_addr = 32'h48; st_req = 1'b1; st_we = 1'b0; st_addr = 32'h4C;
            gc = -1; first_st = 1'b1;
            for (int i = 0; i < 40 && gc < 0; i++) begin
                step();
                if (if_gnt || st_gnt) begin
                    gc = cyc; first_st = st_gnt;
                end
            end
            if_req = 1'b0; st_req = 1'b0;
            chk($sformatf("L%0d post_reset_fetch_first", LAT), first_st, 0);
            rc = -1;
            for (int i = 0; i < 40 && rc < 0; i++) begin
                step();
                if (if_rvalid) begin
                    rc = cyc; rd = if_rdata;
                end
            end
            chk($sformatf("L%0d post_reset_data", LAT), rd, 32'h5A12FFB7);
            wait_idle();
            $display("L%0d fetch rd addr=00000048 after reset gnt@%0d rv@%0d data=%h",
                     LAT, gc, rc, rd);
            repeat (3) step();
            fin = 1'b1;
        end
    end

    initial begin : top
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30000 && !ok; i++) begin
            @(posedge clk);
            ok = g_lat[0].fin && g_lat[1].fin && g_lat[2].fin;
        end
        chk("scripts_finished", ok, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
